// File: rtl/uart_cmd_decoder.sv
// Byte-level framer for 4-byte write frames (SYNC, ADDR, DATA, CSUM) received from a UART.
// Good frames strobe a register write and answer ACK; corrupt frames answer NAK.
module uart_cmd_decoder #(
  parameter logic [7:0]  SYNC    = 8'h55,
  parameter logic [7:0]  ACK     = 8'h06,
  parameter logic [7:0]  NAK     = 8'h15,
  parameter logic [19:0] TIMEOUT = 20'd500000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_SYNC, S_ADDR, S_DATA, S_CSUM, S_RESP, S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d, data_q, data_d, resp_q, resp_d;
  logic [7:0]  tx_data_q, tx_data_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic        tx_start_q, tx_start_d, wr_en_q, wr_en_d;
  logic        frame_err_q, frame_err_d, busy_q, busy_d;

  logic [7:0]  sum;
  logic        csum_ok, expire;
  logic [7:0]  resp;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_d      = resp_q;
    tx_data_d   = tx_data_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    tx_start_d  = 1'b0;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    sum         = addr_q + data_q;
    csum_ok     = (rx_data == ~sum);
    resp        = csum_ok ? ACK : NAK;
    // A byte arriving on the expiry cycle takes priority over the timeout.
    expire      = (cnt_q == TIMEOUT) && !rx_valid;

    unique case (state_q)
      S_SYNC: if (rx_valid && rx_data == SYNC) state_d = S_ADDR;
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = S_DATA;
        end else if (expire) begin
          frame_err_d = 1'b1;
          state_d     = S_SYNC;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = S_CSUM;
        end else if (expire) begin
          frame_err_d = 1'b1;
          state_d     = S_SYNC;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (csum_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            frame_err_d = 1'b1;
          end
          resp_d = resp;
          // Idle transmitter: skip S_RESP so the response starts alongside the strobe.
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = resp;
            state_d    = S_WAIT;
          end else begin
            state_d = S_RESP;
          end
        end else if (expire) begin
          frame_err_d = 1'b1;
          state_d     = S_SYNC;
        end
      end
      S_RESP: begin
        if (expire) begin
          state_d = S_SYNC;
        end else if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = resp_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT:  if (tx_busy || expire) state_d = S_SYNC;
      default: state_d = S_SYNC;
    endcase

    if (rx_valid || state_d == S_SYNC) cnt_d = '0;
    else if (cnt_q != TIMEOUT)         cnt_d = cnt_q + 20'd1;
    else                               cnt_d = cnt_q;

    busy_d = (state_d != S_SYNC);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_SYNC;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      tx_data_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tx_start_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_q      <= resp_d;
      tx_data_q   <= tx_data_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tx_start_q  <= tx_start_d;
      wr_en_q     <= wr_en_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: good/bad frames, garbage, timeout, busy transmitter, reset.
module tb_uart_cmd_decoder;

  localparam logic [19:0] T = 20'd2000;

  logic       clk = 1'b0;
  logic       nRst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int n_tx = 0, n_wr = 0, n_err = 0, n_both = 0;

  uart_cmd_decoder #(.TIMEOUT(T)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the rising edge; the stimulus only touches them on falling edges.
  always @(posedge clk) begin
    if (nRst) begin
      if (tx_start)           n_tx++;
      if (wr_en)              n_wr++;
      if (frame_err)          n_err++;
      if (wr_en && frame_err) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_tx = 0; n_wr = 0; n_err = 0;
  endtask

  // Drives one byte for one cycle; returns on the falling edge after it was sampled.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Transmitter accepts the pending byte: one cycle of tx_busy.
  task automatic handshake();
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int waited;
    bit seen;
    nRst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    nRst = 1'b1;

    // 1: good frame, idle transmitter
    clear_counts();
    send_byte(8'h55); send_byte(8'h12); send_byte(8'h34);
    check("t1_busy_mid", busy, 1);
    send_byte(8'hB9);
    check("t1_wr_en", wr_en, 1);
    check("t1_wr_addr", wr_addr, 8'h12);
    check("t1_wr_data", wr_data, 8'h34);
    check("t1_frame_err", frame_err, 0);
    check("t1_tx_start", tx_start, 1);
    check("t1_tx_data", tx_data, 8'h06);
    @(negedge clk);
    check("t1_wr_en_drop", wr_en, 0);
    check("t1_tx_start_drop", tx_start, 0);
    check("t1_tx_data_hold", tx_data, 8'h06);
    check("t1_wr_addr_hold", wr_addr, 8'h12);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    check("t1_idle", busy, 0);
    repeat (2) @(negedge clk);
    check("t1_n_tx", n_tx, 1);
    check("t1_n_wr", n_wr, 1);
    check("t1_n_err", n_err, 0);

    // 2: checksum failure
    clear_counts();
    send_byte(8'h55); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    check("t2_frame_err", frame_err, 1);
    check("t2_wr_en", wr_en, 0);
    check("t2_tx_start", tx_start, 1);
    check("t2_tx_data", tx_data, 8'h15);
    handshake();
    check("t2_idle", busy, 0);
    check("t2_n_tx", n_tx, 1);
    check("t2_n_wr", n_wr, 0);
    check("t2_n_err", n_err, 1);

    // 3: leading garbage ignored
    clear_counts();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hAA);
    check("t3_garbage_busy", busy, 0);
    check("t3_garbage_err", n_err, 0);
    send_byte(8'h55); send_byte(8'hA0); send_byte(8'h0F); send_byte(8'h50);
    check("t3_wr_en", wr_en, 1);
    check("t3_wr_addr", wr_addr, 8'hA0);
    check("t3_wr_data", wr_data, 8'h0F);
    check("t3_tx_data", tx_data, 8'h06);
    handshake();
    check("t3_n_err", n_err, 0);

    // 4: inter-byte timeout, then recovery
    clear_counts();
    send_byte(8'h55); send_byte(8'h12);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < int'(T) + 20) begin
      @(negedge clk);
      waited++;
      if (frame_err) seen = 1'b1;
    end
    check("t4_timeout_seen", seen, 1);
    check("t4_timeout_cycles", waited, int'(T) + 1);
    check("t4_idle", busy, 0);
    @(negedge clk);
    check("t4_err_one_cycle", frame_err, 0);
    check("t4_n_tx", n_tx, 0);
    check("t4_n_err", n_err, 1);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'hFC);
    check("t4_wr_en", wr_en, 1);
    check("t4_wr_addr", wr_addr, 8'h01);
    check("t4_wr_data", wr_data, 8'h02);
    handshake();

    // 4b: byte landing on the expiry cycle wins over the timeout
    clear_counts();
    send_byte(8'h55);
    repeat (int'(T) - 1) @(negedge clk);
    send_byte(8'h10);
    check("t4b_no_err", frame_err, 0);
    check("t4b_busy", busy, 1);
    send_byte(8'h20); send_byte(8'hCF);
    check("t4b_wr_en", wr_en, 1);
    check("t4b_wr_addr", wr_addr, 8'h10);
    handshake();
    check("t4b_n_err", n_err, 0);

    // 5: transmitter busy for 1000 cycles
    clear_counts();
    tx_busy = 1'b1;
    send_byte(8'h55); send_byte(8'h12); send_byte(8'h34); send_byte(8'hB9);
    check("t5_wr_en", wr_en, 1);
    check("t5_tx_start_blocked", tx_start, 0);
    repeat (1000) @(negedge clk);
    check("t5_n_tx_held", n_tx, 0);
    check("t5_busy_held", busy, 1);
    tx_busy = 1'b0;
    @(negedge clk);
    check("t5_tx_start", tx_start, 1);
    check("t5_tx_data", tx_data, 8'h06);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    check("t5_tx_start_drop", tx_start, 0);
    check("t5_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("t5_n_tx", n_tx, 1);
    check("t5_n_wr", n_wr, 1);

    // 6: reset mid-frame
    send_byte(8'h55); send_byte(8'h12); send_byte(8'h34);
    check("t6_busy_before", busy, 1);
    nRst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_wr_addr", wr_addr, 0);
    check("t6_tx_data", tx_data, 0);
    check("t6_wr_en", wr_en, 0);
    @(negedge clk);
    nRst = 1'b1;
    clear_counts();
    send_byte(8'hB9);
    repeat (3) @(negedge clk);
    check("t6_stray_csum_wr", n_wr, 0);
    check("t6_stray_csum_busy", busy, 0);
    send_byte(8'h55); send_byte(8'hA0); send_byte(8'h0F); send_byte(8'h50);
    check("t6_wr_en", wr_en, 1);
    check("t6_wr_addr_new", wr_addr, 8'hA0);
    handshake();
    check("t6_n_tx", n_tx, 1);

    check("never_wr_and_err", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
